rotator_hex_display: RTL and testbench



---
 rtl/rotator_hex_display_pkg.sv | 32 +++
 rtl/rotator_hex_display_hex_to_seg7.sv | 11 +
 rtl/rotator_hex_display.sv | 114 +++++++++++
 tb/tb_rotator_hex_display.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rotator_hex_display_pkg.sv
// Shared slot type, seven-segment glyph constants and blank patterns for the
// rotator hex display.
package rotator_hex_display_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2
    } slot_e;

    // Active-high gfedcba glyphs for hex digits 0..F.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] GLYPH_R   = 7'h50;  // segments e, g
    localparam logic [6:0] GLYPH_L   = 7'h38;  // segments d, e, f
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [2:0] AN_BLANK  = 3'b111;

    function automatic logic [2:0] slot_anode(input slot_e slot);
        case (slot)
            DIG1:    return 3'b101;
            DIG2:    return 3'b011;
            default: return 3'b110;
        endcase
    endfunction

endpackage

// File: rtl/rotator_hex_display_hex_to_seg7.sv
// Combinational 4-bit to seven-segment glyph decoder (active-high gfedcba).
module hex_to_seg7
    import rotator_hex_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = HEX_GLYPH[nibble_i];

endmodule

// File: rtl/rotator_hex_display.sv
// Scanned 3-digit seven-segment driver: two hex digits of the rotator result
// plus a direction letter, snapshotted once per frame to avoid tearing.
module rotator_hex_display
    import rotator_hex_display_pkg::*;
#(
    parameter int DIV_COUNT    = 12000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value,
    input  logic       dir,
    input  logic       hold,
    output logic [7:0] seg,
    output logic [2:0] an
);

    localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_COUNT - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);

    logic [DIV_W-1:0] div_q, div_d;
    slot_e            slot_q, slot_d;
    logic [7:0]       snap_val_q, snap_val_d;
    logic             snap_dir_q, snap_dir_d;
    logic             snap_hold_q, snap_hold_d;
    logic             load_pending_q, load_pending_d;
    logic [7:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;

    logic       slot_tick;
    logic       load;
    logic       blank;
    logic       dp;
    logic [3:0] nibble;
    logic [6:0] hex_glyph;
    logic [6:0] glyph;

    assign slot_tick = (div_q == DIV_LAST);
    assign load      = load_pending_q | (slot_tick & (slot_q == DIG2));
    assign blank     = (div_q < BLANK_END);
    assign nibble    = (slot_q == DIG1) ? snap_val_q[7:4] : snap_val_q[3:0];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nibble),
        .glyph_o  (hex_glyph)
    );

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        div_d          = slot_tick ? '0 : div_q + 1'b1;
        slot_d         = slot_q;
        snap_val_d     = snap_val_q;
        snap_dir_d     = snap_dir_q;
        snap_hold_d    = snap_hold_q;
        load_pending_d = load_pending_q;

        if (slot_tick) begin
            case (slot_q)
                DIG0:    slot_d = DIG1;
                DIG1:    slot_d = DIG2;
                default: slot_d = DIG0;
            endcase
        end

        // A held load still latches the hold flag, so dp and freeze switch together.
        if (load) begin
            load_pending_d = 1'b0;
            snap_hold_d    = hold;
            if (!hold) begin
                snap_val_d = value;
                snap_dir_d = dir;
            end
        end
    end

    always_comb begin
        glyph = hex_glyph;
        dp    = 1'b0;
        if (slot_q == DIG2) begin
            glyph = snap_dir_q ? GLYPH_R : GLYPH_L;
            dp    = snap_hold_q;
        end
        seg_d = blank ? SEG_BLANK : ~{dp, glyph};
        an_d  = blank ? AN_BLANK  : slot_anode(slot_q);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            div_q          <= '0;
            slot_q         <= DIG0;
            snap_val_q     <= '0;
            snap_dir_q     <= 1'b0;
            snap_hold_q    <= 1'b0;
            load_pending_q <= 1'b1;
            seg_q          <= SEG_BLANK;
            an_q           <= AN_BLANK;
        end else begin
            div_q          <= div_d;
            slot_q         <= slot_d;
            snap_val_q     <= snap_val_d;
            snap_dir_q     <= snap_dir_d;
            snap_hold_q    <= snap_hold_d;
            load_pending_q <= load_pending_d;
            seg_q          <= seg_d;
            an_q           <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_rotator_hex_display.sv
// Self-checking bench for rotator_hex_display with a short scan (8 cycles per
// slot, 2 blank), using a queue of expected per-cycle outputs.
module tb_rotator_hex_display;

    localparam int DIV_COUNT    = 8;
    localparam int BLANK_CYCLES = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value;
    logic       dir;
    logic       hold;
    logic [7:0] seg;
    logic [2:0] an;

    typedef struct packed {
        logic [7:0] seg;
        logic [2:0] an;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    rotator_hex_display #(
        .DIV_COUNT    (DIV_COUNT),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .dir   (dir),
        .hold  (hold),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [2:0] anode_of(input int s);
        case (s)
            0:       return 3'b110;
            1:       return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    // Queue the expected output for the coming edge, clock it, then compare.
    task automatic tick_cycle(input logic [7:0] e_seg, input logic [2:0] e_an, input string tag);
        exp_t e;
        exp_q.push_back('{seg: e_seg, an: e_an});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("%s an", tag), 32'(an), 32'(e.an));
        check($sformatf("%s seg", tag), 32'(seg), 32'(e.seg));
        check($sformatf("%s an_single_low", tag), 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic run_slot(input int s, input logic [7:0] e_seg, input string fr);
        int lit = 0;
        int blk = 0;
        for (int p = 0; p < DIV_COUNT; p++) begin
            if (p < BLANK_CYCLES)
                tick_cycle(8'hFF, 3'b111, $sformatf("%s d%0d p%0d", fr, s, p));
            else
                tick_cycle(e_seg, anode_of(s), $sformatf("%s d%0d p%0d", fr, s, p));
            if (an == 3'b111)
                blk++;
            else if (an == anode_of(s))
                lit++;
        end
        check($sformatf("%s d%0d lit_cycles", fr, s), 32'(lit), 32'(DIV_COUNT - BLANK_CYCLES));
        check($sformatf("%s d%0d blank_cycles", fr, s), 32'(blk), 32'(BLANK_CYCLES));
    endtask

    task automatic run_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                             input string fr);
        run_slot(0, s0, fr);
        run_slot(1, s1, fr);
        run_slot(2, s2, fr);
    endtask

    initial begin
        logic [7:0] shown_val;
        logic       shown_dir;
        logic [7:0] next_val;
        logic       next_dir;

        reset = 1'b1;
        value = 8'hA5;
        dir   = 1'b1;
        hold  = 1'b0;
        repeat (3) tick_cycle(8'hFF, 3'b111, "reset");

        reset = 1'b0;
        run_frame(8'h92, 8'h88, 8'hAF, "f1");

        // Mid-frame value change stays invisible until the next frame load.
        run_slot(0, 8'h92, "f2");
        value = 8'h3C;
        run_slot(1, 8'h88, "f2");
        run_slot(2, 8'hAF, "f2");
        run_frame(8'hC6, 8'hB0, 8'hAF, "f3");

        dir = 1'b0;
        run_frame(8'hC6, 8'hB0, 8'hAF, "f4");

        run_slot(0, 8'hC6, "f5");
        hold  = 1'b1;
        value = 8'h11;
        run_slot(1, 8'hB0, "f5");
        run_slot(2, 8'hC7, "f5");

        run_slot(0, 8'hC6, "f6");
        hold = 1'b0;
        run_slot(1, 8'hB0, "f6");
        run_slot(2, 8'h47, "f6");

        run_frame(8'hF9, 8'hF9, 8'hC7, "f7");

        // Reset in the middle of DIG2, then restart from DIG0 with a fresh load.
        run_slot(0, 8'hF9, "f8");
        run_slot(1, 8'hF9, "f8");
        tick_cycle(8'hFF, 3'b111, "f8 d2 p0");
        tick_cycle(8'hFF, 3'b111, "f8 d2 p1");
        tick_cycle(8'hC7, 3'b011, "f8 d2 p2");
        tick_cycle(8'hC7, 3'b011, "f8 d2 p3");
        value = 8'hE2;
        dir   = 1'b1;
        reset = 1'b1;
        tick_cycle(8'hFF, 3'b111, "midreset");
        reset = 1'b0;
        run_frame(8'hA4, 8'h86, 8'hAF, "f9");

        shown_val = 8'hE2;
        shown_dir = 1'b1;
        for (int k = 0; k < 10; k++) begin
            string fr;
            fr = $sformatf("r%0d", k);
            run_slot(0, ~{1'b0, hex_glyph(shown_val[3:0])}, fr);
            next_val = 8'($urandom_range(0, 255));
            next_dir = 1'($urandom_range(0, 1));
            value    = next_val;
            dir      = next_dir;
            run_slot(1, ~{1'b0, hex_glyph(shown_val[7:4])}, fr);
            run_slot(2, shown_dir ? 8'hAF : 8'hC7, fr);
            shown_val = next_val;
            shown_dir = next_dir;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
